// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider (DIV/DIVU) that stalls EX until the result is ready
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         abandon any operation in progress
//   start         divide requested; held high with stable operands until ready
//   signed_div    1 = DIV (signed), 0 = DIVU
//   opdata1/2     dividend / divisor
//   result        {remainder, quotient} for HI/LO
//   ready         result valid this cycle
//   stall_for_ex  start & ~ready, combinational
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_for_ex
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             qneg_q, rneg_q;

    logic [WIDTH-1:0] mag1_d, mag2_d, rem_d, quo_d, rem_f, quo_f;
    logic [WIDTH:0]   trial_d;
    logic             qbit_d;

    // -2^(W-1) negates to itself, which read as unsigned is the exact magnitude
    assign mag1_d  = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign mag2_d  = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    // shifted partial remainder is WIDTH+1 bits; its MSB after subtract is the borrow
    assign trial_d = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign qbit_d  = ~trial_d[WIDTH];
    // on a failed subtract the remainder stays below the divisor, so its MSB is 0
    assign rem_d   = qbit_d ? trial_d[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_d   = {quo_q[WIDTH-2:0], qbit_d};
    assign quo_f   = qneg_q ? -quo_d : quo_d;
    assign rem_f   = rneg_q ? -rem_d : rem_d;

    assign ready        = (state_q == DIV_END);
    assign stall_for_ex = start & ~ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            state_q <= DIV_ZERO;
                        end else begin
                            state_q <= DIV_ON;
                            rem_q   <= '0;
                            quo_q   <= mag1_d;
                            dvs_q   <= mag2_d;
                            qneg_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            rneg_q  <= signed_div & opdata1[WIDTH-1];
                            cnt_q   <= '0;
                        end
                    end
                end
                DIV_ZERO: begin
                    result  <= '0;
                    state_q <= DIV_END;
                end
                DIV_ON: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        // last iteration: cnt reaches WIDTH as the signed result is loaded
                        if (cnt_q == LAST) begin
                            result  <= {rem_f, quo_f};
                            state_q <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (!start) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed scoreboard bench for div_seq
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic [63:0] result;
    logic        ready;
    logic        stall_for_ex;

    int          n_total = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_res = '0;
    logic        saw_ready;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .start(start),
        .signed_div(signed_div),
        .opdata1(opdata1),
        .opdata2(opdata2),
        .result(result),
        .ready(ready),
        .stall_for_ex(stall_for_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // called at a falling edge; returns at a falling edge with the DUT back in IDLE
    task automatic run_div(input string tag, input bit sd, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          stalls;
        int          exp_lat;
        logic [63:0] e;
        sb_q.push_back(model(sd, a, b));
        exp_lat = (b == '0) ? 2 : 33;
        signed_div = sd;
        opdata1 = a;
        opdata2 = b;
        start = 1'b1;
        #1;
        lat = 0;
        stalls = 0;
        while (!ready && lat < 100) begin
            if (stall_for_ex) stalls++;
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
        chk({tag, " stall low at ready"}, 64'(stall_for_ex), 64'd0);
        chk({tag, " result"}, result, e);
        @(negedge clk);
        chk({tag, " ready held"}, 64'(ready), 64'd1);
        chk({tag, " result held"}, result, e);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " ready dropped"}, 64'(ready), 64'd0);
        last_res = e;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        #1;
        chk("reset stall", 64'(stall_for_ex), 64'd0);

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);

        // flush at T+10
        signed_div = 1'b0;
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start = 1'b1;
        #1;
        saw_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_ready |= ready;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush ready", 64'(ready), 64'd0);
        chk("flush result kept", result, last_res);
        chk("flush stall", 64'(stall_for_ex), 64'd0);
        chk("flush no early ready", 64'(saw_ready), 64'd0);
        @(negedge clk);
        run_div("restart after flush", 1'b0, 32'd100, 32'd7);

        // start dropped at T+5
        signed_div = 1'b1;
        opdata1 = 32'hFFFF_FFF9;
        opdata2 = 32'd2;
        start = 1'b1;
        #1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ready |= ready;
        end
        chk("cancel no ready", 64'(saw_ready), 64'd0);
        chk("cancel result kept", result, last_res);
        run_div("restart after cancel", 1'b0, 32'd100, 32'd7);

        // reset at T+20
        signed_div = 1'b0;
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start = 1'b1;
        #1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset stall follows start", 64'(stall_for_ex), 64'd1);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("midreset ready", 64'(ready), 64'd0);
        chk("midreset result", result, 64'd0);
        chk("midreset stall", 64'(stall_for_ex), 64'd0);
        last_res = '0;
        @(negedge clk);
        run_div("divu 9/3 after reset", 1'b0, 32'd9, 32'd3);

        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
